// File: rtl/inbuf_wr_cntl.sv
// inbuf_wr_cntl: circular-FIFO write/pointer manager and read-valid regenerator for the input buffer memory
module inbuf_wr_cntl #(
  parameter int INBUF_MEM_DATA_W = 256,
  parameter int INBUF_MEM_ADDR_W = 6,
  parameter int RD_LAT = 1,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        eng_flush,
  input  logic                        host_wr_valid,
  input  logic [INBUF_MEM_DATA_W-1:0] host_wr_data,
  output logic                        host_wr_ready,
  output logic                        host_afull,
  input  logic                        cntl_rd_req,
  output logic                        inbuf_mem_wr_req,
  output logic [INBUF_MEM_ADDR_W-1:0] inbuf_mem_wr_addr,
  output logic [INBUF_MEM_DATA_W-1:0] inbuf_mem_wr_data,
  output logic                        inbuf_mem_rd_req,
  output logic [INBUF_MEM_ADDR_W-1:0] inbuf_mem_rd_addr,
  output logic                        inbuf_mem_rd_data_val,
  output logic [INBUF_MEM_ADDR_W:0]   inbuf_level,
  output logic                        inbuf_empty,
  output logic                        rd_underflow
);
  localparam int AW = INBUF_MEM_ADDR_W;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_LVL = DEPTH - (AW+1)'(AFULL_MARGIN);
  logic clr, wr_ok, rd_ok;
  logic [AW:0] wr_ptr, rd_ptr, level;
  logic [RD_LAT-1:0] val_pipe;
  assign clr = rst | eng_flush;
  assign host_wr_ready = level != DEPTH;
  assign host_afull = level >= AFULL_LVL;
  assign inbuf_empty = level == '0;
  // a read is only granted against stored lines, never against a same-cycle write
  assign wr_ok = host_wr_valid & host_wr_ready & ~clr;
  assign rd_ok = cntl_rd_req & ~inbuf_empty & ~clr;
  assign inbuf_mem_wr_req = wr_ok;
  assign inbuf_mem_wr_addr = wr_ptr[AW-1:0];
  assign inbuf_mem_wr_data = host_wr_data;
  assign inbuf_mem_rd_req = rd_ok;
  assign inbuf_mem_rd_addr = rd_ptr[AW-1:0];
  assign inbuf_mem_rd_data_val = val_pipe[RD_LAT-1];
  assign inbuf_level = level;
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      rd_underflow <= 1'b0;
      val_pipe <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(wr_ok);
      rd_ptr <= rd_ptr + (AW+1)'(rd_ok);
      level <= level + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      rd_underflow <= rd_underflow | (cntl_rd_req & inbuf_empty);
      val_pipe <= (val_pipe << 1) | RD_LAT'(rd_ok);
    end
  end
endmodule

// File: tb/tb_inbuf_wr_cntl.sv
// tb_inbuf_wr_cntl: scoreboard bench; expected read data/timing queued at grant, popped when rd_data_val appears
module tb_inbuf_wr_cntl;
  localparam int DW = 256;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, eng_flush, host_wr_valid, cntl_rd_req;
  logic [DW-1:0] host_wr_data, wr_data;
  logic host_wr_ready, host_afull, wr_req, rd_req, val, empty, und;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0] level;

  inbuf_wr_cntl #(.INBUF_MEM_DATA_W(DW), .INBUF_MEM_ADDR_W(AW), .RD_LAT(1), .AFULL_MARGIN(2)) u_dut (
    .clk(clk), .rst(rst), .eng_flush(eng_flush),
    .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready), .host_afull(host_afull), .cntl_rd_req(cntl_rd_req),
    .inbuf_mem_wr_req(wr_req), .inbuf_mem_wr_addr(wr_addr), .inbuf_mem_wr_data(wr_data),
    .inbuf_mem_rd_req(rd_req), .inbuf_mem_rd_addr(rd_addr), .inbuf_mem_rd_data_val(val),
    .inbuf_level(level), .inbuf_empty(empty), .rd_underflow(und));

  logic b_rst, b_flush, b_wv, b_rd;
  logic [DW-1:0] b_wd, b_wdata;
  logic b_ready, b_afull, b_wr_req, b_rd_req, b_val, b_empty, b_und;
  logic [AW-1:0] b_wr_addr, b_rd_addr;
  logic [AW:0] b_level;

  inbuf_wr_cntl #(.INBUF_MEM_DATA_W(DW), .INBUF_MEM_ADDR_W(AW), .RD_LAT(3), .AFULL_MARGIN(2)) u_dut3 (
    .clk(clk), .rst(b_rst), .eng_flush(b_flush),
    .host_wr_valid(b_wv), .host_wr_data(b_wd),
    .host_wr_ready(b_ready), .host_afull(b_afull), .cntl_rd_req(b_rd),
    .inbuf_mem_wr_req(b_wr_req), .inbuf_mem_wr_addr(b_wr_addr), .inbuf_mem_wr_data(b_wdata),
    .inbuf_mem_rd_req(b_rd_req), .inbuf_mem_rd_addr(b_rd_addr), .inbuf_mem_rd_data_val(b_val),
    .inbuf_level(b_level), .inbuf_empty(b_empty), .rd_underflow(b_und));

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // memory model driven by the DUT strobes, RD_LAT=1
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdq;
  always @(posedge clk) begin
    if (wr_req) mem[wr_addr] <= wr_data;
    if (rd_req) rdq <= mem[rd_addr];
  end

  typedef struct {logic [DW-1:0] d; int due;} exp_t;
  exp_t exp_q[$];
  exp_t e_m;
  logic [DW-1:0] wq[$];
  int ml = 0, mw = 0, mr = 0;
  bit mu = 0;

  always @(negedge clk) begin
    if (val === 1'b1) begin
      if (exp_q.size() == 0) chk("val_without_grant", val, 0);
      else begin
        e_m = exp_q.pop_front();
        chk("val_cycle", cyc_cnt, e_m.due);
        chk("rd_data", rdq, e_m.d);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc_cnt) begin
      void'(exp_q.pop_front());
      chk("val_missing", val, 1);
    end
  end

  task automatic cyc(bit rs, bit fl, bit wv, logic [DW-1:0] wd, bit rr);
    bit clr, wok, rok, emp;
    rst = rs; eng_flush = fl; host_wr_valid = wv; host_wr_data = wd; cntl_rd_req = rr;
    #1;
    clr = rs | fl;
    emp = ml == 0;
    wok = wv && ml < DEPTH && !clr;
    rok = rr && !emp && !clr;
    chk("level", level, ml);
    chk("empty", empty, emp);
    chk("wr_ready", host_wr_ready, ml < DEPTH);
    chk("afull", host_afull, DEPTH - ml <= 2);
    chk("underflow", und, mu);
    chk("wr_req", wr_req, wok);
    if (wok) begin
      chk("wr_addr", wr_addr, mw % DEPTH);
      chk("wr_data", wr_data, wd);
    end
    chk("rd_req", rd_req, rok);
    if (rok) chk("rd_addr", rd_addr, mr % DEPTH);
    if (clr) begin
      ml = 0; mw = 0; mr = 0; mu = 0;
      exp_q.delete();
      wq.delete();
    end else begin
      if (wok) begin wq.push_back(wd); mw = (mw + 1) % 128; ml++; end
      if (rok) begin exp_q.push_back('{wq.pop_front(), cyc_cnt + 1}); mr = (mr + 1) % 128; ml--; end
      if (rr && emp) mu = 1;
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] pat(int i);
    logic [31:0] w;
    w = 32'hA5000000 + i;
    return {8{w}};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rnd;
    rst = 1; eng_flush = 0; host_wr_valid = 0; host_wr_data = '0; cntl_rd_req = 0;
    b_rst = 1; b_flush = 0; b_wv = 0; b_wd = '0; b_rd = 0;
    @(negedge clk);
    cyc(1, 0, 1, pat(99), 1);
    cyc(1, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, pat(i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, pat(100 + i), 0);
    cyc(0, 0, 1, pat(200), 0);
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 1, pat(201), 0);
    cyc(0, 1, 1, pat(202), 1);
    cyc(0, 0, 1, pat(300), 1);
    cyc(0, 0, 0, '0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, pat(400 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, pat(500 + i), 1);
    for (int i = 0; i < 200; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cyc(0, 0, $urandom_range(0, 1) == 1, rnd, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 70 && ml > 0; i++) cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    b_rst = 0; b_rd = 1;
    #1 chk("b_rd_req_empty", b_rd_req, 0);
    @(negedge clk); b_rd = 0;
    #1 chk("b_underflow_set", b_und, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); b_wv = 1; b_wd = pat(600 + i);
    end
    @(negedge clk); b_wv = 0; b_rd = 1;
    #1 chk("b_rd_req_single", b_rd_req, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); b_rd = 0;
      #1 chk("b_val_latency", b_val, k == 3);
    end
    @(negedge clk); b_rd = 1;
    #1 chk("b_grant_t", b_rd_req, 1);
    @(negedge clk);
    #1 chk("b_grant_t1", b_rd_req, 1);
    @(negedge clk); b_rd = 0; b_flush = 1;
    #1;
    chk("b_level_preflush", b_level, 2);
    chk("b_und_preflush", b_und, 1);
    chk("b_val_t2", b_val, 0);
    @(negedge clk); b_flush = 0;
    #1;
    chk("b_val_t3", b_val, 0);
    chk("b_level_flushed", b_level, 0);
    chk("b_und_flushed", b_und, 0);
    chk("b_wr_addr_flushed", b_wr_addr, 0);
    chk("b_rd_addr_flushed", b_rd_addr, 0);
    chk("b_empty_flushed", b_empty, 1);
    @(negedge clk);
    #1 chk("b_val_t4", b_val, 0);
    @(negedge clk);
    #1 chk("b_val_t5", b_val, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
